byte_stripping: RTL

BYTE_STRIPPING -- requirements
Module: byte_stripping

---
 rtl/byte_stripping_if.sv | 36 +++
 rtl/byte_stripping.sv | 71 +++++++
 2 files changed

// File: rtl/byte_stripping_if.sv
// Byte-stripping bus bundle: the serial byte stream going in and the
// two-lane parallel words, flush marker and pair counter coming out.
interface byte_stripping_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_par_0;
    logic [7:0] data_par_1;
    logic       valid_par_0;
    logic       valid_par_1;
    logic       odd_flush;
    logic [7:0] pair_cnt;

    // Stream source: drives the serial bytes, observes the lane outputs
    modport master (
        output data_in,
        output valid_in,
        input  data_par_0,
        input  data_par_1,
        input  valid_par_0,
        input  valid_par_1,
        input  odd_flush,
        input  pair_cnt
    );

    // Stripper: consumes the serial bytes, produces the lane outputs
    modport slave (
        input  data_in,
        input  valid_in,
        output data_par_0,
        output data_par_1,
        output valid_par_0,
        output valid_par_1,
        output odd_flush,
        output pair_cnt
    );
endinterface

// File: rtl/byte_stripping.sv
// Byte stripper: splits a serial byte stream into two lanes.
// Even-position bytes go to lane 0 and odd-position bytes go to lane 1.
// A lone lane-0 byte that waits FLUSH_GAP idle edges is flushed on its own.
module byte_stripping #(
    parameter int FLUSH_GAP = 1
) (
    input  logic            clk_2f,
    input  logic            reset_L,
    byte_stripping_if.slave bus
);

    typedef enum logic {
        EMPTY,
        HALF
    } state_t;

    // The gap counter value seen on the idle edge that triggers the flush
    localparam logic [3:0] GAP_LAST = 4'(FLUSH_GAP - 1);

    state_t     state;
    logic [3:0] gap;
    logic [7:0] hold0;

    // Pairing state machine with registered lane outputs; the qualifiers default low each edge
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state           <= EMPTY;
            gap             <= 4'd0;
            hold0           <= 8'h00;
            bus.data_par_0  <= 8'h00;
            bus.data_par_1  <= 8'h00;
            bus.valid_par_0 <= 1'b0;
            bus.valid_par_1 <= 1'b0;
            bus.odd_flush   <= 1'b0;
            bus.pair_cnt    <= 8'h00;
        end else begin
            bus.valid_par_0 <= 1'b0;
            bus.valid_par_1 <= 1'b0;
            bus.odd_flush   <= 1'b0;
            unique case (state)
                EMPTY: begin
                    if (bus.valid_in) begin
                        hold0 <= bus.data_in;
                        gap   <= 4'd0;
                        state <= HALF;
                    end
                end
                HALF: begin
                    if (bus.valid_in) begin
                        bus.data_par_0  <= hold0;
                        bus.data_par_1  <= bus.data_in;
                        bus.valid_par_0 <= 1'b1;
                        bus.valid_par_1 <= 1'b1;
                        bus.pair_cnt    <= bus.pair_cnt + 8'd1;
                        state           <= EMPTY;
                    end else if (gap == GAP_LAST) begin
                        bus.data_par_0  <= hold0;
                        bus.data_par_1  <= 8'h00;
                        bus.valid_par_0 <= 1'b1;
                        bus.odd_flush   <= 1'b1;
                        bus.pair_cnt    <= bus.pair_cnt + 8'd1;
                        state           <= EMPTY;
                    end else begin
                        gap <= gap + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule
